// File: rtl/model_vector_pu.sv
// model_vector_pu
//   Vector processing unit. Streams two operand vectors element by element and
//   produces either an element-wise result stream (add/sub/mul) or a single
//   dot-product result, selected by MODE at START.
//
// Ports
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   START, READY        begin operation / one-cycle completion pulse
//   MODE, SIZE_IN       operation select and vector length, latched at START
//   DATA_ENABLE         high while an element can be accepted
//   DATA_IN_ENABLE      element strobe qualifying DATA_A_IN / DATA_B_IN
//   DATA_OUT_ENABLE     one-cycle valid pulse for DATA_OUT
//   DATA_OUT            element result or dot-product result
//   OVERFLOW            sticky overflow flag for the current operation
//
// state         | meaning
// STARTER_STATE | idle, waiting for START (also the READY cycle)
// INPUT_STATE   | accepting elements, DATA_ENABLE high
// ENDER_STATE   | all elements taken; READY (and dot result) registered here

module model_vector_pu #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [1:0]              MODE,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  output logic                    DATA_ENABLE,
  input  logic                    DATA_IN_ENABLE,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic                    DATA_OUT_ENABLE,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    OVERFLOW
);

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_MUL = 2'b10;
  localparam logic [1:0] MODE_DOT = 2'b11;

  typedef enum logic [1:0] {
    STARTER_STATE = 2'd0,
    INPUT_STATE   = 2'd1,
    ENDER_STATE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [1:0]              op_mode;
  logic [CONTROL_SIZE-1:0] op_size;
  logic [CONTROL_SIZE-1:0] counter;
  logic [DATA_SIZE-1:0]    accumulator;

  logic start_accept;
  logic element_accept;
  logic last_element;

  logic [DATA_SIZE:0]     sum;
  logic [2*DATA_SIZE-1:0] product;
  logic [DATA_SIZE:0]     acc_sum;
  logic [DATA_SIZE-1:0]   element_result;
  logic                   element_overflow;

  assign start_accept   = (state == STARTER_STATE) && START;
  assign element_accept = (state == INPUT_STATE) && DATA_IN_ENABLE;
  // op_size is nonzero whenever INPUT_STATE is reachable, so size-1 cannot wrap here
  assign last_element   = (counter == op_size - CONTROL_SIZE'(1));

  assign sum     = {1'b0, DATA_A_IN} + {1'b0, DATA_B_IN};
  assign product = {{DATA_SIZE{1'b0}}, DATA_A_IN} * {{DATA_SIZE{1'b0}}, DATA_B_IN};
  assign acc_sum = {1'b0, accumulator} + {1'b0, product[DATA_SIZE-1:0]};

  // In dot mode element_result is the next accumulator value
  always_comb begin
    element_result   = '0;
    element_overflow = 1'b0;
    case (op_mode)
      MODE_ADD: begin
        element_result   = sum[DATA_SIZE-1:0];
        element_overflow = sum[DATA_SIZE];
      end
      MODE_SUB: begin
        element_result   = DATA_A_IN - DATA_B_IN;
        element_overflow = DATA_A_IN < DATA_B_IN;
      end
      MODE_MUL: begin
        element_result   = product[DATA_SIZE-1:0];
        element_overflow = |product[2*DATA_SIZE-1:DATA_SIZE];
      end
      default: begin
        element_result   = acc_sum[DATA_SIZE-1:0];
        element_overflow = (|product[2*DATA_SIZE-1:DATA_SIZE]) | acc_sum[DATA_SIZE];
      end
    endcase
  end

  always_comb begin
    state_next  = state;
    DATA_ENABLE = 1'b0;
    case (state)
      STARTER_STATE: begin
        if (START) begin
          state_next = (SIZE_IN == '0) ? ENDER_STATE : INPUT_STATE;
        end
      end
      INPUT_STATE: begin
        DATA_ENABLE = 1'b1;
        if (DATA_IN_ENABLE && last_element) begin
          state_next = ENDER_STATE;
        end
      end
      ENDER_STATE: begin
        state_next = STARTER_STATE;
      end
      default: begin
        state_next = STARTER_STATE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= STARTER_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_mode         <= MODE_ADD;
      op_size         <= '0;
      counter         <= '0;
      accumulator     <= '0;
      READY           <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_OUT        <= '0;
      OVERFLOW        <= 1'b0;
    end else begin
      READY           <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;

      if (start_accept) begin
        op_mode     <= MODE;
        op_size     <= SIZE_IN;
        counter     <= '0;
        accumulator <= '0;
        OVERFLOW    <= 1'b0;
      end

      if (element_accept) begin
        counter  <= counter + CONTROL_SIZE'(1);
        OVERFLOW <= OVERFLOW | element_overflow;
        if (op_mode == MODE_DOT) begin
          accumulator <= element_result;
        end else begin
          DATA_OUT        <= element_result;
          DATA_OUT_ENABLE <= 1'b1;
        end
      end

      if (state == ENDER_STATE) begin
        READY <= 1'b1;
        if (op_mode == MODE_DOT) begin
          DATA_OUT        <= accumulator;
          DATA_OUT_ENABLE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_model_vector_pu.sv
// tb_model_vector_pu
//   Scoreboard bench for model_vector_pu (DATA_SIZE=8). Each operation computes
//   its expected outputs with plain integer arithmetic and queues them; a
//   monitor pops and compares on every DATA_OUT_ENABLE / READY pulse.

module tb_model_vector_pu;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [1:0]    mode;
  logic [CW-1:0] size_in;
  logic          data_enable;
  logic          data_in_enable;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          data_out_enable;
  logic [DW-1:0] data_out;
  logic          overflow;

  model_vector_pu #(.DATA_SIZE(DW), .CONTROL_SIZE(CW)) dut (
    .CLK            (clk),
    .RST            (rst),
    .START          (start),
    .READY          (ready),
    .MODE           (mode),
    .SIZE_IN        (size_in),
    .DATA_ENABLE    (data_enable),
    .DATA_IN_ENABLE (data_in_enable),
    .DATA_A_IN      (data_a),
    .DATA_B_IN      (data_b),
    .DATA_OUT_ENABLE(data_out_enable),
    .DATA_OUT       (data_out),
    .OVERFLOW       (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_data_q[$];
  bit            exp_final_q[$];
  bit            exp_ovf_q[$];
  int            va[16];
  int            vb[16];

  logic [DW-1:0] mon_data;
  bit            mon_flag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every output pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (data_out_enable) begin
        if (exp_data_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_data_out: got %0d, no output expected at %0t", data_out, $time);
        end else begin
          mon_data = exp_data_q.pop_front();
          mon_flag = exp_final_q.pop_front();
          chk("data_out", data_out, mon_data);
          chk("dot_result_with_ready", ready, mon_flag);
        end
      end
      if (ready) begin
        if (exp_ovf_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got 1, no completion expected at %0t", $time);
        end else begin
          mon_flag = exp_ovf_q.pop_front();
          chk("overflow_at_ready", overflow, mon_flag);
        end
      end
    end
  end

  // Reference model: plain integer arithmetic modulo 256
  task automatic model_op(input logic [1:0] m, input int n);
    int  acc;
    int  r;
    bit  ovf;
    acc = 0;
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'd0: begin
          r = va[i] + vb[i];
          if (r > 255) ovf = 1;
          exp_data_q.push_back(8'(r % 256));
          exp_final_q.push_back(1'b0);
        end
        2'd1: begin
          if (va[i] < vb[i]) ovf = 1;
          exp_data_q.push_back(8'((va[i] - vb[i] + 256) % 256));
          exp_final_q.push_back(1'b0);
        end
        2'd2: begin
          r = va[i] * vb[i];
          if (r > 255) ovf = 1;
          exp_data_q.push_back(8'(r % 256));
          exp_final_q.push_back(1'b0);
        end
        default: begin
          r = va[i] * vb[i];
          if (r > 255) ovf = 1;
          acc = acc + (r % 256);
          if (acc > 255) ovf = 1;
          acc = acc % 256;
        end
      endcase
    end
    if (m == 2'd3) begin
      exp_data_q.push_back(8'(acc));
      exp_final_q.push_back(1'b1);
    end
    exp_ovf_q.push_back(ovf);
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge of the READY
  // cycle so a following call starts back-to-back.
  task automatic run_op(input logic [1:0] m, input int n, input int gap, input bit noisy);
    int g;
    model_op(m, n);
    start   = 1'b1;
    mode    = m;
    size_in = CW'(n);
    @(negedge clk);
    start   = 1'b0;
    mode    = 2'($urandom);
    size_in = CW'($urandom);
    chk("data_enable_after_start", data_enable, (n != 0));
    chk("overflow_cleared", overflow, 1'b0);
    if (n == 0) begin
      @(negedge clk);
      chk("ready_size0", ready, 1'b1);
      chk("doe_size0", data_out_enable, (m == 2'd3));
      return;
    end
    for (int i = 0; i < n; i++) begin
      g = (gap < 0) ? int'($urandom_range(2, 0)) : ((i == 0) ? 0 : gap);
      for (int k = 0; k < g; k++) begin
        data_in_enable = 1'b0;
        data_a = DW'($urandom);
        data_b = DW'($urandom);
        if (noisy) begin
          start   = 1'($urandom);
          mode    = 2'($urandom);
          size_in = CW'($urandom);
        end
        @(negedge clk);
        chk("doe_in_gap", data_out_enable, 1'b0);
      end
      chk("data_enable_in_input", data_enable, 1'b1);
      data_in_enable = 1'b1;
      data_a = DW'(va[i]);
      data_b = DW'(vb[i]);
      if (noisy) begin
        start   = 1'($urandom);
        mode    = 2'($urandom);
        size_in = CW'($urandom);
      end
      @(negedge clk);
      data_in_enable = 1'b0;
      start = 1'b0;
      chk("doe_after_strobe", data_out_enable, (m != 2'd3));
    end
    chk("data_enable_drop", data_enable, 1'b0);
    chk("ready_not_early", ready, 1'b0);
    @(negedge clk);
    chk("ready_pulse", ready, 1'b1);
  endtask

  task automatic set_vec(input int i, input int a, input int b);
    va[i] = a;
    vb[i] = b;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    size_in = '0;
    data_in_enable = 1'b0;
    data_a = '0;
    data_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1'b0);
    chk("reset_data_enable", data_enable, 1'b0);
    chk("reset_doe", data_out_enable, 1'b0);
    chk("reset_data_out", data_out, 0);
    chk("reset_overflow", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // element-wise add, consecutive strobes: 5, 7, 9
    set_vec(0, 1, 4); set_vec(1, 2, 5); set_vec(2, 3, 6);
    run_op(2'd0, 3, 0, 1'b0);
    @(negedge clk);

    // dot with one idle cycle between strobes: 32
    run_op(2'd3, 3, 1, 1'b0);
    @(negedge clk);

    // overflow cases, then a clean add clears the flag
    set_vec(0, 200, 100); run_op(2'd0, 1, 0, 1'b0);
    set_vec(0, 3, 5);     run_op(2'd1, 1, 0, 1'b0);
    set_vec(0, 16, 16);   run_op(2'd2, 1, 0, 1'b0);
    set_vec(0, 1, 1);     run_op(2'd0, 1, 0, 1'b0);
    @(negedge clk);

    // zero-length vectors
    run_op(2'd3, 0, 0, 1'b0);
    @(negedge clk);
    run_op(2'd0, 0, 0, 1'b0);
    @(negedge clk);

    // strobes while idle are ignored
    for (int k = 0; k < 3; k++) begin
      data_in_enable = 1'b1;
      data_a = DW'($urandom);
      data_b = DW'($urandom);
      @(negedge clk);
      chk("idle_strobe_no_doe", data_out_enable, 1'b0);
      chk("idle_strobe_no_ready", ready, 1'b0);
    end
    data_in_enable = 1'b0;

    // back-to-back, second op with START noise during INPUT_STATE
    set_vec(0, 10, 20); set_vec(1, 30, 40);
    run_op(2'd0, 2, 0, 1'b0);
    set_vec(0, 7, 9); set_vec(1, 12, 30);
    run_op(2'd2, 2, -1, 1'b1);
    @(negedge clk);

    // reset mid-operation after 2 of 4 dot elements
    start = 1'b1;
    mode = 2'd3;
    size_in = CW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      data_in_enable = 1'b1;
      data_a = DW'(16);
      data_b = DW'(16);
      @(negedge clk);
    end
    data_in_enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midreset_ready", ready, 1'b0);
    chk("midreset_data_enable", data_enable, 1'b0);
    chk("midreset_doe", data_out_enable, 1'b0);
    chk("midreset_data_out", data_out, 0);
    chk("midreset_overflow", overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_vec(0, 3, 7);
    run_op(2'd3, 1, 0, 1'b0);
    @(negedge clk);

    // randomized operations
    for (int t = 0; t < 40; t++) begin
      int n;
      n = int'($urandom_range(5, 0));
      for (int i = 0; i < n; i++) begin
        va[i] = ($urandom % 2) ? int'($urandom_range(15, 0)) : int'($urandom_range(255, 0));
        vb[i] = ($urandom % 2) ? int'($urandom_range(15, 0)) : int'($urandom_range(255, 0));
      end
      run_op(2'($urandom), n, -1, 1'($urandom));
      if ($urandom % 2) begin
        data_in_enable = 1'($urandom);
        @(negedge clk);
        data_in_enable = 1'b0;
      end
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_data_drained", exp_data_q.size(), 0);
    chk("scoreboard_ready_drained", exp_ovf_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
